// File: rtl/key_break_conditioner.sv
// rtl/key_break_conditioner.sv - debounced board keys plus a PC breakpoint FSM for the clock-control block
module key_break_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PC_W            = 32
) (
  input  logic            iCLK_50,
  input  logic            Reset,
  input  logic [3:0]      iKEY_raw,
  input  logic            iCPU_CLK,
  input  logic [PC_W-1:0] iPC,
  input  logic [PC_W-1:0] iBreakAddr,
  input  logic            iBreakEn,
  output logic [3:0]      oKEY,
  output logic [3:0]      oKEYPress,
  output logic [3:0]      oKEYRelease,
  output logic            oBreak
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, HALTED, SKIP} state_t;

  logic [3:0]       key_s1, key_s2;
  logic [CNT_W-1:0] cnt [4];

  // Each key restarts its count whenever the synchronized input agrees with the accepted level.
  always_ff @(posedge iCLK_50 or posedge Reset) begin
    if (Reset) begin
      key_s1      <= '1;
      key_s2      <= '1;
      oKEY        <= '1;
      oKEYPress   <= '0;
      oKEYRelease <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      key_s1 <= iKEY_raw;
      key_s2 <= key_s1;
      for (int i = 0; i < 4; i++) begin
        oKEYPress[i]   <= 1'b0;
        oKEYRelease[i] <= 1'b0;
        if (key_s2[i] == oKEY[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          oKEY[i]        <= key_s2[i];
          cnt[i]         <= '0;
          oKEYPress[i]   <= ~key_s2[i];
          oKEYRelease[i] <= key_s2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  logic [2:0]      cpu_sync;
  logic            cpu_rise;
  logic            cmp_en;
  logic [PC_W-1:0] pc_q;
  logic            pc_match;

  assign cpu_rise = cpu_sync[1] & ~cpu_sync[2];
  assign pc_match = (pc_q == iBreakAddr);

  // The PC is sampled two cycles after the CPU edge, by which time it has long settled.
  always_ff @(posedge iCLK_50 or posedge Reset) begin
    if (Reset) begin
      cpu_sync <= '0;
      cmp_en   <= 1'b0;
      pc_q     <= '0;
    end else begin
      cpu_sync <= {cpu_sync[1:0], iCPU_CLK};
      cmp_en   <= cpu_rise;
      if (cpu_rise) pc_q <= iPC;
    end
  end

  state_t state, state_nxt;
  logic   break_nxt;

  always_ff @(posedge iCLK_50 or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      oBreak <= 1'b0;
    end else begin
      state  <= state_nxt;
      oBreak <= break_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!iBreakEn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARMED;
        ARMED:   if (cmp_en && pc_match) state_nxt = HALTED;
        HALTED:  if (oKEYPress[2]) state_nxt = SKIP;
        SKIP:    if (cmp_en && !pc_match) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    break_nxt = (state_nxt == HALTED);
  end

endmodule

// File: tb/tb_key_break_conditioner.sv
// tb/tb_key_break_conditioner.sv - randomized bench for key_break_conditioner against a sample-window model
module tb_key_break_conditioner;

  localparam int DEB  = 16;
  localparam int PC_W = 32;

  logic            iCLK_50 = 1'b0;
  logic            Reset = 1'b1;
  logic [3:0]      iKEY_raw = 4'hF;
  logic            iCPU_CLK = 1'b0;
  logic [PC_W-1:0] iPC = '0;
  logic [PC_W-1:0] iBreakAddr = 32'h10;
  logic            iBreakEn = 1'b0;
  logic [3:0]      oKEY, oKEYPress, oKEYRelease;
  logic            oBreak;

  key_break_conditioner #(.DEBOUNCE_CYCLES(DEB), .PC_W(PC_W)) dut (
    .iCLK_50(iCLK_50), .Reset(Reset), .iKEY_raw(iKEY_raw), .iCPU_CLK(iCPU_CLK),
    .iPC(iPC), .iBreakAddr(iBreakAddr), .iBreakEn(iBreakEn),
    .oKEY(oKEY), .oKEYPress(oKEYPress), .oKEYRelease(oKEYRelease), .oBreak(oBreak)
  );

  initial forever #10 iCLK_50 = ~iCLK_50;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;
  bit brk_checked = 1'b1;

  // Model keeps raw per-edge samples; index j holds the sample taken j edges ago.
  localparam int M_OFF = 0, M_WATCH = 1, M_HALT = 2, M_SKIP = 3;
  logic [3:0]      key_hist [DEB+2];
  logic            cpu_hist [5];
  logic [PC_W-1:0] pc_prev;
  logic [3:0]      m_key, m_press, m_rel;
  int              m_mode;
  logic            m_break;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < DEB + 2; j++) key_hist[j] = 4'hF;
    for (int j = 0; j < 5; j++) cpu_hist[j] = 1'b0;
    pc_prev = '0;
    m_key   = 4'hF;
    m_press = '0;
    m_rel   = '0;
    m_mode  = M_OFF;
    m_break = 1'b0;
  endtask

  task automatic model_step();
    logic [PC_W-1:0] pc_seen;
    logic cpu_edge, hit, press2, stable;
    if (Reset) begin
      model_reset();
      return;
    end
    for (int j = DEB + 1; j > 0; j--) key_hist[j] = key_hist[j-1];
    key_hist[0] = iKEY_raw;
    for (int j = 4; j > 0; j--) cpu_hist[j] = cpu_hist[j-1];
    cpu_hist[0] = iCPU_CLK;
    pc_seen = pc_prev;
    pc_prev = iPC;
    cpu_edge = cpu_hist[3] && !cpu_hist[4];
    hit      = (pc_seen == iBreakAddr);
    press2   = m_press[2];
    for (int k = 0; k < 4; k++) begin
      m_press[k] = 1'b0;
      m_rel[k]   = 1'b0;
      stable = 1'b1;
      for (int j = 2; j < DEB + 2; j++) if (key_hist[j][k] == m_key[k]) stable = 1'b0;
      if (stable) begin
        m_key[k] = ~m_key[k];
        if (m_key[k]) m_rel[k] = 1'b1;
        else          m_press[k] = 1'b1;
      end
    end
    if (!iBreakEn) m_mode = M_OFF;
    else if (m_mode == M_OFF) m_mode = M_WATCH;
    else if (m_mode == M_WATCH && cpu_edge && hit) m_mode = M_HALT;
    else if (m_mode == M_HALT && press2) m_mode = M_SKIP;
    else if (m_mode == M_SKIP && cpu_edge && !hit) m_mode = M_WATCH;
    m_break = (m_mode == M_HALT);
  endtask

  task automatic tick();
    @(posedge iCLK_50);
    model_step();
    @(negedge iCLK_50);
    check("keys", {oKEY, oKEYPress, oKEYRelease}, {m_key, m_press, m_rel});
    if (brk_checked) check("brk", oBreak, m_break);
  endtask

  task automatic cpu_cycle(input logic [PC_W-1:0] pc, input int half, output int rise_lat);
    iPC = pc;
    iCPU_CLK = 1'b1;
    rise_lat = 0;
    for (int i = 1; i <= half; i++) begin
      tick();
      if (rise_lat == 0 && oBreak) rise_lat = i;
    end
    iCPU_CLK = 1'b0;
    for (int i = 0; i < half; i++) tick();
  endtask

  function automatic logic [PC_W-1:0] pick_pc();
    case ($urandom_range(0, 2))
      0:       return 32'h8;
      1:       return 32'h10;
      default: return 32'h14;
    endcase
  endfunction

  initial begin
    int lat, cnt, pcyc;
    int hold [4];
    model_reset();

    repeat (3) tick();
    check("rst_key", oKEY, 4'hF);
    check("rst_press", oKEYPress, 4'h0);
    check("rst_release", oKEYRelease, 4'h0);
    check("rst_brk", oBreak, 1'b0);
    Reset = 1'b0;
    repeat (3) tick();

    // Clean press on key 1.
    iKEY_raw[1] = 1'b0;
    lat = 0; cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (lat == 0 && !oKEY[1]) lat = i;
      cnt += int'(oKEYPress[1]);
    end
    check("k1_latency", lat, 2 + DEB);
    check("k1_presses", cnt, 1);
    iKEY_raw[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt += int'(oKEYRelease[1]);
    end
    check("k1_releases", cnt, 1);

    // Bouncing key 3 never settles long enough.
    cnt = 0;
    for (int i = 0; i < 130; i++) begin
      if (i < 100 && i % 5 == 0) iKEY_raw[3] = ~iKEY_raw[3];
      if (i == 100) iKEY_raw[3] = 1'b1;
      tick();
      cnt += int'(oKEYPress[3]) + int'(oKEYRelease[3]);
    end
    check("k3_pulses", cnt, 0);
    check("k3_level", oKEY[3], 1'b1);

    // Independent random bouncing on all keys.
    for (int k = 0; k < 4; k++) hold[k] = $urandom_range(1, 30);
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          iKEY_raw[k] = ~iKEY_raw[k];
          hold[k] = $urandom_range(1, 30);
        end
      end
      tick();
    end
    iKEY_raw = 4'hF;
    repeat (25) tick();
    check("keys_settled", oKEY, 4'hF);

    // Breakpoint at 0x10 with a 20-cycle CPU clock.
    iBreakEn = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      cpu_cycle(32'(p * 4), 10, lat);
      check("brk_before_hit", oBreak, 1'b0);
    end
    cpu_cycle(32'h10, 10, lat);
    check("brk_within_5", (lat >= 1 && lat <= 5), 1'b1);
    cpu_cycle(32'h10, 10, lat);
    cpu_cycle(32'h10, 10, lat);
    check("brk_hold", oBreak, 1'b1);

    iKEY_raw[2] = 1'b0;
    pcyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pcyc < 0 && oKEYPress[2]) begin
        pcyc = i;
        check("brk_at_press", oBreak, 1'b1);
      end else if (pcyc > 0 && i == pcyc + 1) begin
        check("brk_fall_after_press", oBreak, 1'b0);
      end
    end
    check("press2_seen", pcyc > 0, 1'b1);
    iKEY_raw[2] = 1'b1;
    repeat (25) tick();
    cpu_cycle(32'h10, 10, lat);
    cpu_cycle(32'h10, 10, lat);
    check("skip_ignores_match", oBreak, 1'b0);
    cpu_cycle(32'h14, 10, lat);
    check("skip_leave", oBreak, 1'b0);
    cpu_cycle(32'h10, 10, lat);
    check("rehalt", oBreak, 1'b1);

    // Asynchronous reset while halted with key 0 held down.
    iKEY_raw[0] = 1'b0;
    repeat (25) tick();
    check("k0_low", oKEY[0], 1'b0);
    check("halted_before_reset", oBreak, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_brk", oBreak, 1'b0);
    check("async_rst_key", oKEY, 4'hF);
    repeat (3) tick();
    Reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (lat == 0 && !oKEY[0]) lat = i;
    end
    check("post_rst_k0_latency", lat, 2 + DEB);
    check("post_rst_brk", oBreak, 1'b0);
    iKEY_raw[0] = 1'b1;
    repeat (25) tick();

    // Dropping the enable while halted.
    cpu_cycle(32'h10, 10, lat);
    check("halt_before_drop", oBreak, 1'b1);
    iBreakEn = 1'b0;
    tick();
    check("en_drop", oBreak, 1'b0);
    cpu_cycle(32'h10, 10, lat);
    cpu_cycle(32'h10, 10, lat);
    check("disabled_ignores", oBreak, 1'b0);
    iBreakEn = 1'b1;
    tick();
    cpu_cycle(32'h10, 10, lat);
    check("en_back", oBreak, 1'b1);

    // Random CPU traffic, key 2 activity and enable drops.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) iKEY_raw[2] = ~iKEY_raw[2];
      if ($urandom_range(0, 15) == 0) iBreakEn = ~iBreakEn;
      cpu_cycle(pick_pc(), $urandom_range(4, 8), lat);
    end
    iKEY_raw[2] = 1'b1;

    // Over-fast CPU clock: oBreak is unspecified, but disabling must recover.
    brk_checked = 1'b0;
    iBreakEn = 1'b1;
    for (int n = 0; n < 20; n++) cpu_cycle(pick_pc(), $urandom_range(1, 2), lat);
    iBreakEn = 1'b0;
    tick();
    brk_checked = 1'b1;
    check("fast_recover", oBreak, 1'b0);
    iBreakEn = 1'b1;
    repeat (25) tick();
    cpu_cycle(32'h10, 6, lat);
    check("fast_then_halt", oBreak, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_break_conditioner.md
KEY_BREAK_CONDITIONER -- requirements
Module: key_break_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of stable iCLK_50 cycles required to accept a key change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter PC_W, default 32, the program-counter width.
REQ-003 Port iCLK_50  in  1  SHALL be the system clock (50 MHz).
REQ-004 Port Reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port iKEY_raw  in  4  SHALL carry the raw board push-buttons, active-low and asynchronous.
REQ-006 Port iCPU_CLK  in  1  SHALL carry the processor clock; it is asynchronous to iCLK_50.
REQ-007 Port iPC  in  PC_W  SHALL carry the processor PC, changing on iCPU_CLK rising edges.
REQ-008 Port iBreakAddr  in  PC_W  SHALL carry the breakpoint address, quasi-static.
REQ-009 Port iBreakEn  in  1  SHALL enable the breakpoint, quasi-static.
REQ-010 Port oKEY  out  4  SHALL carry the debounced keys, active-low level, for the clock-control iKEY input.
REQ-011 Port oKEYPress  out  4  SHALL carry a 1-cycle pulse per key on each accepted press (1->0).
REQ-012 Port oKEYRelease  out  4  SHALL carry a 1-cycle pulse per key on each accepted release (0->1).
REQ-013 Port oBreak  out  1  SHALL carry the breakpoint hit level, for the clock-control iBreak input.

Function
REQ-014 Each iKEY_raw bit SHALL pass through a 2-flop synchronizer; the synchronizer flops reset to 1.
REQ-015 Each key SHALL have an independent counter, ceil(log2(DEBOUNCE_CYCLES)) bits wide.
- The counter SHALL clear whenever the synchronized value equals oKEY[i].
- Otherwise it SHALL increment by 1 each cycle.
REQ-016 When a key counter equals DEBOUNCE_CYCLES-1 while the key still differs, the block SHALL, on the next edge:
- load oKEY[i] with the synchronized value;
- clear the counter;
- pulse oKEYPress[i] (new value 0) or oKEYRelease[i] (new value 1) for exactly one cycle.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no change on oKEY and no pulse; the counter SHALL restart from 0 on every bounce.
REQ-018 Simultaneous transitions on several keys SHALL be handled independently, with no priority between keys.
REQ-019 iCPU_CLK SHALL be synchronized by 3 flops; a CPU edge event (cpu_rise) is synced bit2=0 and bit1=1, a 1-cycle pulse.
REQ-020 On cpu_rise, iPC SHALL be captured into pc_q; pc_q is used for comparison on the following cycle.
REQ-021 The break FSM SHALL have states IDLE, ARMED, HALTED, SKIP, with these transitions:
- IDLE->ARMED when iBreakEn=1.
- Any state->IDLE when iBreakEn=0, with oBreak deasserted the next cycle.
- ARMED->HALTED on the cycle after cpu_rise when pc_q==iBreakAddr.
- HALTED->SKIP on oKEYPress[2].
- SKIP->ARMED on the cycle after cpu_rise when pc_q!=iBreakAddr.
REQ-022 oBreak SHALL be registered and equal 1 exactly while the state is HALTED.
REQ-023 In SKIP, matches SHALL be ignored, so a single breakpoint does not re-halt until the PC leaves the address.
REQ-024 If oKEYPress[2] and a match occur in the same cycle while ARMED, the match SHALL win (go to HALTED).
REQ-025 oKEYPress[2] outside HALTED SHALL have no effect on the FSM.
REQ-026 Break detection SHALL be guaranteed only for an iCPU_CLK high and low time of at least 4 iCLK_50 cycles each.
- Faster CPU clocks SHALL never lock up the FSM.
- oBreak is undefined under faster CPU clocks.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 While Reset=1, the block SHALL hold:
- oKEY=4'b1111 and all synchronizer flops=1;
- all counters=0;
- oKEYPress=oKEYRelease=0;
- CPU-clock synchronizer=0 and pc_q=0;
- state=IDLE and oBreak=0.
REQ-029 Reset asserted mid-debounce or in HALTED SHALL abort immediately: outputs at reset values asynchronously, oBreak falling without waiting for a clock edge.
REQ-030 After Reset deasserts, the first accepted key change SHALL require a full DEBOUNCE_CYCLES of stable input.

Verification (DEBOUNCE_CYCLES=16)
REQ-031 Bench SHALL hold iKEY_raw[1]=0 steady for 30 cycles -> oKEY[1] falls once, 2+16 cycles after the input edge, with a single oKEYPress[1] pulse.
REQ-032 Bench SHALL toggle iKEY_raw[3] every 5 cycles for 100 cycles, then hold it at 1 -> oKEY[3] stays 1 with no pulses.
REQ-033 Bench SHALL set iBreakEn=1, iBreakAddr=0x0000_0010, iCPU_CLK period 20 cycles, with the PC stepping 0x0,0x4,...
- Required response: oBreak rises within 5 cycles of the CPU edge presenting 0x10.
- oBreak stays 1 while the PC holds.
REQ-034 From HALTED, bench SHALL press KEY[2] -> oBreak falls 1 cycle after oKEYPress[2].
- Further CPU edges with PC=0x10 keep oBreak=0.
- After the PC reaches 0x14 and later returns to 0x10, oBreak is asserted again.
REQ-035 Bench SHALL assert Reset while HALTED with oKEY[0]=0 -> oBreak=0 and oKEY=4'b1111 without an iCLK_50 edge; the state is IDLE after release.
REQ-036 Bench SHALL drop iBreakEn in HALTED -> oBreak=0 on the next cycle, state IDLE, and matches are ignored until iBreakEn returns to 1.
